// File: rtl/cdc_hs_pkg.sv
// cdc_hs_pkg: shared state type and default constants for the toggle-handshake crossing.
package cdc_hs_pkg;
    typedef enum logic [1:0] {PEER_RST, IDLE, WAIT_ACK, ERR} hs_tx_state_t;
    localparam int HS_SYNC_STAGES = 2;
    localparam int HS_TIMEOUT     = 256;
endpackage

// File: rtl/cdc_sync_bit.sv
// cdc_sync_bit: multi-flop single-bit synchronizer; ports clk_a, rst_a_n, d (async in), q (synchronized out).
module cdc_sync_bit #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_a,
    input  logic rst_a_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync;
    always_ff @(posedge clk_a or negedge rst_a_n)
        if (!rst_a_n) sync <= {STAGES{RESET_VAL}};
        else          sync <= {sync[STAGES-2:0], d};
    assign q = sync[STAGES-1];
endmodule

// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: source side of a toggle handshake; ports s_valid/s_ready/s_data in, xfer_req/xfer_data out, xfer_ack/peer_rst_n async in, busy/done/drop/timeout_err status, err_clr.
module cdc_hs_tx
    import cdc_hs_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = HS_SYNC_STAGES,
    parameter int TIMEOUT     = HS_TIMEOUT
) (
    input  logic              clk_a,
    input  logic              rst_a_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              xfer_req,
    output logic [DATA_W-1:0] xfer_data,
    input  logic              xfer_ack,
    input  logic              peer_rst_n,
    output logic              busy,
    output logic              done,
    output logic              drop,
    output logic              timeout_err,
    input  logic              err_clr
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    hs_tx_state_t  state;
    logic [CW-1:0] cnt;
    logic          ack_s, peer_s;

    // Local reset reads as "peer in reset" so the FSM always re-arms through PEER_RST.
    cdc_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_ack_sync (
        .clk_a(clk_a), .rst_a_n(rst_a_n), .d(xfer_ack), .q(ack_s)
    );
    cdc_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_peer_sync (
        .clk_a(clk_a), .rst_a_n(rst_a_n), .d(peer_rst_n), .q(peer_s)
    );

    assign s_ready = state == IDLE;
    assign busy    = state != IDLE;

    always_ff @(posedge clk_a or negedge rst_a_n)
        if (!rst_a_n) begin
            state       <= PEER_RST;
            xfer_req    <= 1'b0;
            xfer_data   <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            drop        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done <= 1'b0;
            drop <= 1'b0;
            if (state != PEER_RST && !peer_s) begin
                // Peer reset outranks everything; both toggles restart from 0.
                state       <= PEER_RST;
                xfer_req    <= 1'b0;
                timeout_err <= 1'b0;
                drop        <= state == WAIT_ACK || state == ERR;
            end else begin
                case (state)
                    PEER_RST: begin
                        xfer_req <= 1'b0;
                        if (peer_s && !ack_s) state <= IDLE;
                    end
                    IDLE: if (s_valid) begin
                        xfer_data <= s_data;
                        xfer_req  <= ~xfer_req;
                        cnt       <= '0;
                        state     <= WAIT_ACK;
                    end
                    WAIT_ACK: begin
                        if (ack_s == xfer_req) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
                            state       <= ERR;
                            timeout_err <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(cnt != '1);
                        end
                    end
                    ERR: if (err_clr) begin
                        timeout_err <= 1'b0;
                        cnt         <= '0;
                        state       <= ack_s == xfer_req ? IDLE : WAIT_ACK;
                    end
                    default: state <= PEER_RST;
                endcase
            end
        end
endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb_cdc_hs_tx: directed vector table plus hand-written corner sequences for cdc_hs_tx.
module tb_cdc_hs_tx;
    logic       clk_a = 1'b0;
    logic       rst_a_n, s_valid, s_ready, xfer_req, xfer_ack, peer_rst_n;
    logic       busy, done, drop, timeout_err, err_clr, loop, ack_drv;
    logic [7:0] s_data, xfer_data;
    int         errors = 0, checks = 0;

    always #5 clk_a = ~clk_a;
    assign xfer_ack = loop ? xfer_req : ack_drv;

    cdc_hs_tx #(.DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(8)) dut (
        .clk_a(clk_a), .rst_a_n(rst_a_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .xfer_req(xfer_req), .xfer_data(xfer_data), .xfer_ack(xfer_ack),
        .peer_rst_n(peer_rst_n), .busy(busy), .done(done), .drop(drop),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    typedef struct {
        logic        sv;
        logic [7:0]  sd;
        logic [13:0] exp;
    } vec_t;

    function automatic logic [13:0] e(logic rdy, logic req, logic [7:0] d, logic bsy, logic dn);
        return {rdy, req, d, bsy, dn, 2'b00};
    endfunction

    function automatic logic [13:0] obs();
        return {s_ready, xfer_req, xfer_data, busy, done, drop, timeout_err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_a);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        s_valid = 1'b1;
        s_data  = d;
        step();
        s_valid = 1'b0;
        chk("accept", {s_ready, busy, xfer_data}, {1'b0, 1'b1, d});
    endtask

    vec_t vecs[12];

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 8'h00, e(0, 0, 8'h00, 1, 0)};
        vecs[1]  = '{1'b0, 8'h00, e(0, 0, 8'h00, 1, 0)};
        vecs[2]  = '{1'b1, 8'hA5, e(1, 0, 8'h00, 0, 0)};
        vecs[3]  = '{1'b1, 8'hA5, e(0, 1, 8'hA5, 1, 0)};
        vecs[4]  = '{1'b1, 8'h3C, e(0, 1, 8'hA5, 1, 0)};
        vecs[5]  = '{1'b1, 8'h3C, e(0, 1, 8'hA5, 1, 0)};
        vecs[6]  = '{1'b1, 8'h3C, e(1, 1, 8'hA5, 0, 1)};
        vecs[7]  = '{1'b1, 8'h3C, e(0, 0, 8'h3C, 1, 0)};
        vecs[8]  = '{1'b0, 8'h00, e(0, 0, 8'h3C, 1, 0)};
        vecs[9]  = '{1'b0, 8'h00, e(0, 0, 8'h3C, 1, 0)};
        vecs[10] = '{1'b0, 8'h00, e(1, 0, 8'h3C, 0, 1)};
        vecs[11] = '{1'b0, 8'h00, e(1, 0, 8'h3C, 0, 0)};

        rst_a_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; peer_rst_n = 1'b1;
        err_clr = 1'b0; loop = 1'b1; ack_drv = 1'b0;
        #3;
        chk("reset_state", obs(), e(0, 0, 8'h00, 1, 0));
        step();
        rst_a_n = 1'b1;

        // Loopback: reset release then back-to-back 0xA5, 0x3C
        for (int i = 0; i < 12; i++) begin
            s_valid = vecs[i].sv;
            s_data  = vecs[i].sd;
            step();
            chk($sformatf("vec%0d", i), obs(), vecs[i].exp);
        end

        // Timeout with ack stuck low
        loop = 1'b0; ack_drv = 1'b0;
        send(8'h11);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("to_edge%0d", k), {timeout_err, busy}, {k == 8, 1'b1});
        end
        ack_drv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("late_ack_stays_err", {timeout_err, busy, done}, 3'b110);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_clr_idle", {s_ready, done, timeout_err, xfer_data}, {3'b100, 8'h11});

        // Ack lands on the same edge the timeout would expire
        send(8'h22);
        for (int k = 1; k <= 8; k++) begin
            if (k == 6) ack_drv = 1'b0;
            step();
            if (k == 7) chk("ack_vs_to_pre", {done, timeout_err, busy}, 3'b001);
            if (k == 8) chk("ack_vs_to", {done, timeout_err, s_ready}, 3'b101);
        end

        // Peer reset pulse coinciding with ack arrival
        send(8'h33);
        ack_drv = 1'b1; peer_rst_n = 1'b0;
        step();
        peer_rst_n = 1'b1;
        step();
        chk("pre_peer_rst", {drop, done, busy}, 3'b001);
        step();
        chk("peer_vs_ack", {drop, done, xfer_req, s_ready, busy}, 5'b10001);
        for (int k = 4; k <= 5; k++) begin
            step();
            chk("peer_rst_hold", {drop, s_ready, xfer_req}, 3'b000);
        end
        ack_drv = 1'b0;
        step();
        step();
        chk("peer_rst_wait_ack0", s_ready, 1'b0);
        step();
        chk("peer_rst_exit", {s_ready, xfer_data}, {1'b1, 8'h33});

        // Local reset asserted mid-WAIT_ACK
        send(8'h44);
        step();
        chk("wait_ack_pending", {busy, xfer_req}, 2'b11);
        #2 rst_a_n = 1'b0; peer_rst_n = 1'b0;
        #1;
        chk("async_reset", obs(), e(0, 0, 8'h00, 1, 0));
        step();
        rst_a_n = 1'b1;
        for (int k = 0; k < 10; k++) step();
        chk("peer_held_low", {s_ready, busy}, 2'b01);
        peer_rst_n = 1'b1;
        step();
        step();
        chk("peer_release_2", s_ready, 1'b0);
        step();
        chk("peer_release_3", s_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cdc_hs_tx.md
# cdc_hs_tx

Source side of a toggle-handshake clock-domain crossing, living entirely in the `clk_a` domain. It accepts a data word over a valid/ready interface, holds it stable on `xfer_data`, and flips `xfer_req`. It then waits for the far-domain receiver to echo the toggle on `xfer_ack`. It also tracks the receiver's asynchronous reset (`peer_rst_n`) so that a far-side reset resynchronises both toggles instead of leaving the handshake wedged.

## Interface
Parameters:
- `DATA_W`, 8: width of the transferred word.
- `SYNC_STAGES`, 2: flop count of each input synchronizer; minimum 2.
- `TIMEOUT`, 256: maximum `clk_a` cycles spent in WAIT_ACK before an error; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-low):
- `clk_a`  in  1  sole clock.
- `rst_a_n`  in  1  asynchronous active-low reset.
- `s_valid`  in  1  source word valid.
- `s_ready`  out  1  block can accept; high only in IDLE.
- `s_data`  in  DATA_W  source word.
- `xfer_req`  out  1  request toggle to the far domain; registered.
- `xfer_data`  out  DATA_W  held word; registered; stable while a request is pending.
- `xfer_ack`  in  1  acknowledge toggle from the far domain; asynchronous.
- `peer_rst_n`  in  1  far-domain reset, active-low; asynchronous.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse when an ack completes a transfer.
- `drop`  out  1  one-cycle pulse when a pending transfer is aborted by peer reset.
- `timeout_err`  out  1  high while in ERR.
- `err_clr`  in  1  clears ERR.

## Operation
- `ack_s` is `xfer_ack` passed through SYNC_STAGES flops, reset value 0.
- `peer_s` is `peer_rst_n` passed through SYNC_STAGES flops, reset value 0, so a local reset is treated as "peer in reset".
- The state machine has four states: PEER_RST (reset state), IDLE, WAIT_ACK and ERR.
- PEER_RST:
  - `xfer_req` is forced to 0.
  - Moves to IDLE when `peer_s`==1 and `ack_s`==0.
- IDLE, when `s_valid`&`s_ready`:
  - `xfer_data` <= `s_data`.
  - `xfer_req` <= ~`xfer_req`.
  - Timeout counter <= 0.
  - Moves to WAIT_ACK.
- WAIT_ACK:
  - If `ack_s`==`xfer_req`: move to IDLE and pulse `done`.
  - Else, if TIMEOUT!=0 and count==TIMEOUT-1: move to ERR.
  - Else: count+1.
  - The counter is $clog2(TIMEOUT+1) bits wide and never wraps.
- ERR:
  - A late ack does not leave ERR.
  - On `err_clr`: if `ack_s`==`xfer_req`, move to IDLE (no `done`); otherwise return to WAIT_ACK with the counter cleared.
- Peer reset (`peer_s`==0) from any state other than PEER_RST:
  - Moves to PEER_RST next edge.
  - `drop` pulses if the state was WAIT_ACK or ERR.
  - `xfer_data` retains its value.
- Priority on the same edge: peer reset > ack > timeout > `err_clr`.
- `s_valid` while `s_ready`==0 is ignored; `s_data` is not sampled.

## Timing
- Reset values: `s_ready` 0, `xfer_req` 0, `xfer_data` 0, `busy` 1, `done` 0, `drop` 0, `timeout_err` 0; state is PEER_RST.
- After reset release with `peer_rst_n`=1 and `xfer_ack`=0, `s_ready` rises after SYNC_STAGES+1 edges.
- Acceptance at edge N: `xfer_req` and `xfer_data` change at N; `s_ready` falls at N.
- With `xfer_ack` wired to `xfer_req`: `ack_s` matches after edge N+SYNC_STAGES; IDLE and `done` occur at edge N+SYNC_STAGES+1.
  - Throughput is one word per SYNC_STAGES+2 cycles.
- `done`, `drop` and `timeout_err` are registered.
- `s_ready` and `busy` are decoded from the state register.
- Assertion of `rst_a_n` mid-transfer returns every output to its reset value immediately.

## Structure
- Package `cdc_hs_pkg` contains:
  - the state typedef `hs_tx_state_t` (PEER_RST, IDLE, WAIT_ACK, ERR);
  - default constants `HS_SYNC_STAGES`=2 and `HS_TIMEOUT`=256.
- Sub-module `cdc_sync_bit` (parameters STAGES and RESET_VAL, asynchronous active-low reset) is instanced twice: once for `xfer_ack`, once for `peer_rst_n`.

## Test plan
- Loopback (`xfer_ack`=`xfer_req`), SYNC_STAGES=2: send 0xA5 then 0x3C back-to-back.
  - Required: `xfer_req` toggles 0->1->0, `done` pulses 4 cycles apart, `xfer_data` holds each word until its `done`.
- Reset release with `peer_rst_n`=1: `s_ready` 0 for 2 edges, then 1 from the 3rd edge.
  - Holding `peer_rst_n`=0 keeps `s_ready`=0 indefinitely.
- `xfer_ack` tied 0, TIMEOUT=8: send 0x11.
  - Required: ERR and `timeout_err`=1 on the 8th edge after acceptance.
  - Then toggle `xfer_ack` and pulse `err_clr`: IDLE, no `done`, `s_ready`=1.
- Pending transfer, then `peer_rst_n` pulsed low for 1 cycle.
  - Required: `drop` pulses once, `xfer_req`=0, PEER_RST held until `ack_s`==0 and `peer_s`==1, then IDLE.
- Ack arriving on the same edge as timeout expiry, and peer reset on the same edge as ack.
  - Required: the first gives `done` and IDLE with no error; the second gives PEER_RST with `drop` and no `done`.
- `rst_a_n` asserted mid-WAIT_ACK.
  - Required: all outputs return to reset values asynchronously; `xfer_data`=0, `xfer_req`=0.
